lab2_proc_proc_dpath_xm_stage: RTL and testbench
================================================

LAB2_PROC_PROC_DPATH_XM_STAGE -- requirements
Module: lab2_proc_proc_dpath_xm_stage

Interface
REQ-001 SHALL have parameter p_nbits, default 32, datapath width of result, target and link values.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_val, input, 1, execute-stage entry valid.
REQ-005 SHALL have port in_rdy, output, 1, stage can accept an entry this cycle.
REQ-006 SHALL have port alu_out, input, p_nbits, ALU result.
REQ-007 SHALL have port ops_eq / ops_lt / ops_ltu, input, 1 each, ALU comparison flags.
REQ-008 SHALL have port br_type, input, 3, branch kind: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jump.
REQ-009 SHALL have port br_target, input, p_nbits, branch/jump target.
REQ-010 SHALL have port pc_plus4, input, p_nbits, link value.
REQ-011 SHALL have port rf_waddr / rf_wen, input, 5 / 1, destination register and write enable.
REQ-012 SHALL have port flush, input, 1, kill all buffered and incoming entries.
REQ-013 SHALL have port out_val / out_rdy, output / input, 1 each, memory-stage handshake.
REQ-014 SHALL have port out_result / out_waddr / out_wen, output, p_nbits / 5 / 1, head entry.
REQ-015 SHALL have port redirect_val / redirect_target, output, 1 / p_nbits, registered fetch redirect.

Function
REQ-016 Enqueue SHALL occur when in_val && in_rdy && !flush; dequeue when out_val && out_rdy && !flush.
REQ-017 Taken SHALL be: beq ops_eq; bne !ops_eq; blt ops_lt; bge !ops_lt; bltu ops_ltu; bgeu !ops_ltu; jump 1; none 0.
REQ-018 Stored result SHALL be pc_plus4 when br_type==7, otherwise alu_out.
REQ-019 Stored wen SHALL be forced 0 for br_type 1..6; otherwise rf_wen.
REQ-020 Buffer SHALL be a 2-entry FIFO with occupancy FSM EMPTY, ONE, FULL.
REQ-021 FSM transitions: enqueue only +1; dequeue only -1; both: unchanged; flush: to EMPTY.
REQ-022 in_rdy SHALL depend only on state: 1 in EMPTY and ONE, 0 in FULL.
REQ-023 out_val SHALL be 1 in ONE and FULL; out_result/out_waddr/out_wen SHALL present the oldest entry.
REQ-024 Latency SHALL be one cycle: an entry accepted in cycle N is visible on out_* in cycle N+1 if the buffer was EMPTY.
REQ-025 Full throughput: in ONE with simultaneous enqueue and dequeue, one entry per cycle SHALL be sustained without bubbles.
REQ-026 Read and write pointers SHALL wrap modulo 2.
REQ-027 redirect_val SHALL pulse high for exactly one cycle, the cycle after an enqueued entry was taken; redirect_target SHALL hold that entry's br_target.
REQ-028 redirect_target SHALL hold its value when redirect_val is 0.
REQ-029 flush SHALL block enqueue and dequeue in the same cycle and clear redirect_val on the next edge.
REQ-030 Outputs SHALL not change while out_val && !out_rdy except by flush.

Reset
REQ-031 While reset_n is low: state EMPTY, pointers 0, out_val 0, in_rdy 1 after release, redirect_val 0, redirect_target 0, storage 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries and any pending redirect immediately, without waiting for clk.

Structure
REQ-033 A shared package lab2_proc_xm_pkg SHALL hold the br_type encodings and the FSM state typedef.
REQ-034 Storage and pointers SHALL live in one sub-module lab2_proc_xm_skid_buf; branch evaluation and result muxing SHALL stay in the top.

Verification
REQ-035 Bench SHALL cover: after reset, out_val=0 and in_rdy=1; in_val with alu_out=0x0000_0005, rf_waddr=3, rf_wen=1, br_type=0 -> next cycle out_val=1, out_result=5, out_waddr=3, out_wen=1.
REQ-036 Bench SHALL cover: out_rdy=0 with 3 back-to-back entries -> in_rdy=0 after 2 accepted, third held; out_rdy=1 -> drained in order with no loss.
REQ-037 Bench SHALL cover: br_type=3 with ops_lt=1 and br_target=0x200 -> redirect_val=1 for one cycle with target 0x200 and out_wen=0; the same input with ops_lt=0 -> no redirect.
REQ-038 Bench SHALL cover: br_type=7 with pc_plus4=0x104 and rf_waddr=1 -> out_result=0x104, out_wen=1, redirect_val pulses.
REQ-039 Bench SHALL cover: FULL with pending redirect and flush=1 -> next cycle out_val=0, redirect_val=0, in_rdy=1.
REQ-040 Bench SHALL cover: continuous in_val=1 and out_rdy=1 for 10 cycles -> 10 results in order, one per cycle.

Source files
------------

// File: rtl/lab2_proc_xm_pkg.sv
// Shared encodings for the execute/memory (X->M) stage: branch kinds,
// buffer occupancy states and the branch resolution helper.
package lab2_proc_xm_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6,
    BR_JUMP = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } xm_state_e;

  // Resolves a branch from the ALU comparison flags.
  function automatic logic br_taken(input br_type_e bt, input logic eq,
                                    input logic lt, input logic ltu);
    logic t;
    case (bt)
      BR_EQ:   t = eq;
      BR_NE:   t = !eq;
      BR_LT:   t = lt;
      BR_GE:   t = !lt;
      BR_LTU:  t = ltu;
      BR_GEU:  t = !ltu;
      BR_JUMP: t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lab2_proc_xm_skid_buf.sv
// Two-entry FIFO between execute and memory. The occupancy state is exported
// so the parent derives its handshake signals from it alone.
module lab2_proc_xm_skid_buf
  import lab2_proc_xm_pkg::*;
#(
  parameter int p_width = 38
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enq,
  input  logic               deq,
  input  logic               flush,
  input  logic [p_width-1:0] enq_data,
  output xm_state_e          state,
  output logic [p_width-1:0] head_data
);

  logic [p_width-1:0] mem [2];
  logic               wptr;
  logic               rptr;

  // Single-bit pointers wrap modulo 2 by construction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
    end else if (flush) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      if (enq) begin
        mem[wptr] <= enq_data;
        wptr      <= ~wptr;
      end
      if (deq) begin
        rptr <= ~rptr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (enq) state <= ST_ONE;
        ST_ONE: begin
          if (enq && !deq)      state <= ST_FULL;
          else if (deq && !enq) state <= ST_EMPTY;
        end
        ST_FULL:  if (deq) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  assign head_data = mem[rptr];

endmodule

// File: rtl/lab2_proc_proc_dpath_xm_stage.sv
// Execute-to-memory stage: resolves branches, selects the writeback value,
// buffers entries toward memory and raises a registered fetch redirect.
module lab2_proc_proc_dpath_xm_stage
  import lab2_proc_xm_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] alu_out,
  input  logic               ops_eq,
  input  logic               ops_lt,
  input  logic               ops_ltu,
  input  logic [2:0]         br_type,
  input  logic [p_nbits-1:0] br_target,
  input  logic [p_nbits-1:0] pc_plus4,
  input  logic [4:0]         rf_waddr,
  input  logic               rf_wen,
  input  logic               flush,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_result,
  output logic [4:0]         out_waddr,
  output logic               out_wen,
  output logic               redirect_val,
  output logic [p_nbits-1:0] redirect_target
);

  localparam int ENTRY_W = p_nbits + 6;

  br_type_e           bt;
  logic               taken;
  logic               is_cond;
  logic [p_nbits-1:0] result_sel;
  logic               wen_sel;
  logic               enq;
  logic               deq;
  xm_state_e          state;
  logic [ENTRY_W-1:0] head;

  assign bt         = br_type_e'(br_type);
  assign taken      = br_taken(bt, ops_eq, ops_lt, ops_ltu);
  assign is_cond    = (bt != BR_NONE) && (bt != BR_JUMP);
  assign result_sel = (bt == BR_JUMP) ? pc_plus4 : alu_out;
  assign wen_sel    = rf_wen && !is_cond;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high and flush is low; ready never depends on valid, and a presented
  // entry stays stable until it transfers or is flushed.
  assign in_rdy  = (state != ST_FULL);
  assign out_val = (state != ST_EMPTY);
  assign enq     = in_val && in_rdy && !flush;
  assign deq     = out_val && out_rdy && !flush;

  lab2_proc_xm_skid_buf #(
    .p_width (ENTRY_W)
  ) u_skid_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq       (enq),
    .deq       (deq),
    .flush     (flush),
    .enq_data  ({wen_sel, rf_waddr, result_sel}),
    .state     (state),
    .head_data (head)
  );

  assign {out_wen, out_waddr, out_result} = head;

  // The target holds between pulses so fetch can sample it lazily.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_val    <= 1'b0;
      redirect_target <= '0;
    end else if (enq && taken) begin
      redirect_val    <= 1'b1;
      redirect_target <= br_target;
    end else begin
      redirect_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lab2_proc_proc_dpath_xm_stage.sv
// Randomized bench for the X->M stage: a driver predicts accepted entries and
// redirects into queues; a negedge monitor compares DUT outputs against them.
module tb_lab2_proc_proc_dpath_xm_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] alu_out;
  logic        ops_eq, ops_lt, ops_ltu;
  logic [2:0]  br_type;
  logic [31:0] br_target;
  logic [31:0] pc_plus4;
  logic [4:0]  rf_waddr;
  logic        rf_wen;
  logic        flush;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_result;
  logic [4:0]  out_waddr;
  logic        out_wen;
  logic        redirect_val;
  logic [31:0] redirect_target;

  lab2_proc_proc_dpath_xm_stage #(.p_nbits(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .alu_out         (alu_out),
    .ops_eq          (ops_eq),
    .ops_lt          (ops_lt),
    .ops_ltu         (ops_ltu),
    .br_type         (br_type),
    .br_target       (br_target),
    .pc_plus4        (pc_plus4),
    .rf_waddr        (rf_waddr),
    .rf_wen          (rf_wen),
    .flush           (flush),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_result      (out_result),
    .out_waddr       (out_waddr),
    .out_wen         (out_wen),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [69:0] exp_q[$];  // {visible_cycle, wen, waddr, result}
  logic [64:0] rd_q[$];   // {check_cycle, redirect_val, redirect_target}
  logic [31:0] last_tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int vis;
    vis = 0;
    if (reset_n) begin
      foreach (exp_q[i]) if (exp_q[i][69:38] <= cyc) vis++;
      chk("out_val", {63'd0, out_val}, {63'd0, vis > 0});
      chk("in_rdy", {63'd0, in_rdy}, {63'd0, vis < 2});
      if (vis > 0) begin
        chk("out_result", {32'd0, out_result}, {32'd0, exp_q[0][31:0]});
        chk("out_waddr", {59'd0, out_waddr}, {59'd0, exp_q[0][36:32]});
        chk("out_wen", {63'd0, out_wen}, {63'd0, exp_q[0][37]});
        if (out_rdy && !flush) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      if (rd_q.size() > 0 && rd_q[0][64:33] == cyc) begin
        chk("redirect_val", {63'd0, redirect_val}, {63'd0, rd_q[0][32]});
        chk("redirect_target", {32'd0, redirect_target}, {32'd0, rd_q[0][31:0]});
        void'(rd_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] bt, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alu, input logic [31:0] tgt,
                       input logic [31:0] pc4, input logic [4:0] wa, input logic we,
                       input logic fl, input logic ordy, output logic acc);
    logic        tk;
    logic [31:0] tag;
    logic [31:0] res;
    logic        wq;
    @(posedge clk);
    #1;
    in_val    = v;
    br_type   = bt;
    ops_eq    = (a == b);
    ops_lt    = ($signed(a) < $signed(b));
    ops_ltu   = (a < b);
    alu_out   = alu;
    br_target = tgt;
    pc_plus4  = pc4;
    rf_waddr  = wa;
    rf_wen    = we;
    flush     = fl;
    out_rdy   = ordy;
    @(negedge clk);
    acc = v && in_rdy && !fl;
    // Branch outcome from the operands themselves, not the flags.
    case (bt)
      3'd1:    tk = (a == b);
      3'd2:    tk = (a != b);
      3'd3:    tk = ($signed(a) < $signed(b));
      3'd4:    tk = ($signed(a) >= $signed(b));
      3'd5:    tk = (a < b);
      3'd6:    tk = (a >= b);
      3'd7:    tk = 1'b1;
      default: tk = 1'b0;
    endcase
    tag = cyc + 1;
    if (acc) begin
      res = (bt == 3'd7) ? pc4 : alu;
      wq  = (bt >= 3'd1 && bt <= 3'd6) ? 1'b0 : we;
      exp_q.push_back({tag, wq, wa, res});
      if (tk) last_tgt = tgt;
    end
    rd_q.push_back({tag, acc && tk, last_tgt});
  endtask

  task automatic send(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] alu, input logic [31:0] tgt, input logic [31:0] pc4,
                      input logic [4:0] wa, input logic we, input logic ordy,
                      output int tries);
    logic acc;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive(1'b1, bt, a, b, alu, tgt, pc4, wa, we, 1'b0, ordy, acc);
      tries++;
    end
    chk("send_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++)
      drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, ordy, acc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int   tries;
    logic acc;
    logic [31:0] ra, rb;
    reset_n = 1'b0;
    in_val = 0; alu_out = 0; ops_eq = 0; ops_lt = 0; ops_ltu = 0; br_type = 0;
    br_target = 0; pc_plus4 = 0; rf_waddr = 0; rf_wen = 0; flush = 0; out_rdy = 0;
    last_tgt = 0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_val", {63'd0, out_val}, 64'd0);
    chk("rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("rst_redirect_val", {63'd0, redirect_val}, 64'd0);
    chk("rst_redirect_target", {32'd0, redirect_target}, 64'd0);

    // Single ALU result, one-cycle latency.
    send(3'd0, 32'd0, 32'd1, 32'h0000_0005, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, tries);
    idle(2, 1'b1);

    // Backpressure: two accepted, third held, then drained in order.
    send(3'd0, 32'd0, 32'd1, 32'h11, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, tries);
    send(3'd0, 32'd0, 32'd1, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, tries);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 32'd0, 32'd1, 32'h33, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, acc);
      chk("third_held", {63'd0, acc}, 64'd0);
    end
    send(3'd0, 32'd0, 32'd1, 32'h33, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, tries);
    chk("third_tries", tries, 2);
    idle(3, 1'b1);

    // blt taken / not taken.
    send(3'd3, 32'd1, 32'd2, 32'h77, 32'h200, 32'h0, 5'd7, 1'b1, 1'b1, tries);
    idle(2, 1'b1);
    send(3'd3, 32'd2, 32'd1, 32'h78, 32'h200, 32'h0, 5'd7, 1'b1, 1'b1, tries);
    idle(2, 1'b1);

    // Jump writes the link value.
    send(3'd7, 32'd0, 32'd0, 32'hdead, 32'h400, 32'h104, 5'd1, 1'b1, 1'b1, tries);
    idle(2, 1'b1);

    // Flush while FULL with a redirect pending.
    send(3'd0, 32'd0, 32'd1, 32'h55, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, tries);
    send(3'd7, 32'd0, 32'd0, 32'h0, 32'h300, 32'h58, 5'd9, 1'b1, 1'b0, tries);
    drive(1'b1, 3'd7, 32'd0, 32'd0, 32'h0, 32'h500, 32'h5c, 5'd10, 1'b1, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    chk("flush_out_val", {63'd0, out_val}, 64'd0);
    chk("flush_redirect_val", {63'd0, redirect_val}, 64'd0);
    chk("flush_in_rdy", {63'd0, in_rdy}, 64'd1);
    idle(1, 1'b1);

    // Ten back-to-back transfers, one per cycle.
    for (int i = 0; i < 10; i++) begin
      send(3'd0, 32'd0, 32'd1, $urandom, 32'h0, 32'h0, 5'($urandom_range(0, 31)), 1'b1, 1'b1, tries);
      chk("stream_tries", tries, 1);
    end
    idle(2, 1'b1);

    // Random traffic with backpressure and occasional flush.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb, $urandom, $urandom,
            $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, acc);
    end
    idle(4, 1'b1);

    // Asynchronous reset mid-operation with a full buffer and live redirect.
    send(3'd0, 32'd0, 32'd1, 32'h66, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, tries);
    send(3'd7, 32'd0, 32'd0, 32'h0, 32'h600, 32'h70, 5'd3, 1'b1, 1'b0, tries);
    @(posedge clk);
    #1 in_val = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_out_val", {63'd0, out_val}, 64'd0);
    chk("async_rst_in_rdy", {63'd0, in_rdy}, 64'd1);
    chk("async_rst_redirect_val", {63'd0, redirect_val}, 64'd0);
    chk("async_rst_redirect_target", {32'd0, redirect_target}, 64'd0);
    exp_q.delete();
    rd_q.delete();
    last_tgt = 32'd0;
    #1 reset_n = 1'b1;
    idle(2, 1'b1);
    send(3'd0, 32'd0, 32'd1, 32'h99, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, tries);
    idle(3, 1'b1);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
